// File: rtl/csr_pkg.sv
// csr_pkg: shared constants and types for the machine-mode CSR unit.
//   - CSR addresses, SYSTEM opcode, funct3 encodings
//   - trap cause codes, mstatus bit positions and write mask
//   - CSR operation kind and the redirect FSM state enum
package csr_pkg;

    localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

    // funct3 = 000 sub-encodings carried in inst[31:20]
    localparam logic [11:0] SYS_ECALL    = 12'h000;
    localparam logic [11:0] SYS_EBREAK   = 12'h001;
    localparam logic [11:0] SYS_MRET     = 12'h302;

    localparam logic [2:0]  F3_PRIV      = 3'b000;
    localparam logic [2:0]  F3_ILLEGAL   = 3'b100;

    localparam logic [3:0]  CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0]  CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0]  CAUSE_ECALL   = 4'd11;

    localparam int          MSTATUS_MIE    = 3;
    localparam int          MSTATUS_MPIE   = 7;
    localparam int          MSTATUS_MPP_LO = 11;
    localparam int          MSTATUS_MPP_HI = 12;
    localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;

    // Encoded to match funct3[1:0] of the Zicsr instructions.
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } csr_state_e;

endpackage

// File: rtl/csr_decode.sv
// csr_decode: purely combinational decode of a SYSTEM instruction word.
// Ports:
//   i_inst       instruction word
//   o_csr_op     legal Zicsr instruction (address exists, no write to read-only)
//   o_csr_kind   RW / RS / RC
//   o_use_imm    operand is zero-extended inst[19:15]
//   o_csr_write  instruction actually writes the CSR (not write-suppressed)
//   o_rd_nz      rd field is non-zero
//   o_trap       ecall, ebreak or illegal instruction
//   o_illegal    illegal-instruction condition
//   o_mret       mret
//   o_cause      trap cause code (valid with o_trap)
// Build option: CSR_MCYCLE_EN makes the counter addresses legal.
module csr_decode
    import csr_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic        o_csr_op,
    output csr_op_e     o_csr_kind,
    output logic        o_use_imm,
    output logic        o_csr_write,
    output logic        o_rd_nz,
    output logic        o_trap,
    output logic        o_illegal,
    output logic        o_mret,
    output logic [3:0]  o_cause
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [11:0] w_addr;
    logic [4:0]  w_rs1f;
    logic        w_addr_known;
    logic        w_addr_ro;
    logic        w_wants_write;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_addr   = i_inst[31:20];
    assign w_rs1f   = i_inst[19:15];
    assign o_rd_nz  = (i_inst[11:7] != 5'd0);

    always_comb begin
        w_addr_known = 1'b0;
        w_addr_ro    = 1'b0;
        case (w_addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: w_addr_known = 1'b1;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE, CSR_MCYCLEH: w_addr_known = 1'b1;
            CSR_CYCLE, CSR_CYCLEH: begin
                w_addr_known = 1'b1;
                w_addr_ro    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // RW/RWI always write; set/clear forms with a zero source field only read.
    assign w_wants_write = (w_funct3[1:0] == 2'b01) || (w_rs1f != 5'd0);

    always_comb begin
        o_csr_op    = 1'b0;
        o_csr_kind  = CSR_OP_NONE;
        o_use_imm   = w_funct3[2];
        o_csr_write = 1'b0;
        o_trap      = 1'b0;
        o_illegal   = 1'b0;
        o_mret      = 1'b0;
        o_cause     = CAUSE_ILLEGAL;
        if (w_opcode == OPC_SYSTEM) begin
            if (w_funct3 == F3_PRIV) begin
                case (w_addr)
                    SYS_ECALL: begin
                        o_trap  = 1'b1;
                        o_cause = CAUSE_ECALL;
                    end
                    SYS_EBREAK: begin
                        o_trap  = 1'b1;
                        o_cause = CAUSE_EBREAK;
                    end
                    SYS_MRET: o_mret = 1'b1;
                    default: begin
                        o_trap    = 1'b1;
                        o_illegal = 1'b1;
                    end
                endcase
            end else if (w_funct3 == F3_ILLEGAL) begin
                o_trap    = 1'b1;
                o_illegal = 1'b1;
            end else if (!w_addr_known || (w_addr_ro && w_wants_write)) begin
                o_trap    = 1'b1;
                o_illegal = 1'b1;
            end else begin
                o_csr_op    = 1'b1;
                o_csr_kind  = csr_op_e'(w_funct3[1:0]);
                o_csr_write = w_wants_write;
            end
        end
    end

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file (mstatus, mtvec, mepc, mcause) with Zicsr
// read-modify-write, trap entry, mret and a registered one-cycle PC redirect.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   csrunitin_valid/inst/rs1/pc   retiring instruction and its operands
//   csrunitout_rdata         old value of addressed CSR (combinational)
//   csrunitout_rd_write      rd writeback enable (combinational)
//   csrunitout_illegal       illegal-instruction trap (combinational)
//   csrunitout_redirect      one-cycle flush/jump pulse (registered)
//   csrunitout_redirect_pc   jump target while redirect is high
//   csrunitout_mstatus       live mstatus
// Build option: CSR_MCYCLE_EN adds the 64-bit mcycle counter (0xB00/0xB80,
// read-only aliases 0xC00/0xC80).
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csrunitin_valid,
    input  logic [31:0]     csrunitin_inst,
    input  logic [XLEN-1:0] csrunitin_rs1,
    input  logic [XLEN-1:0] csrunitin_pc,
    output logic [XLEN-1:0] csrunitout_rdata,
    output logic            csrunitout_rd_write,
    output logic            csrunitout_redirect,
    output logic [XLEN-1:0] csrunitout_redirect_pc,
    output logic            csrunitout_illegal,
    output logic [XLEN-1:0] csrunitout_mstatus
);

    csr_state_e      r_state, w_state_next;
    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause, r_redirect_pc;
`ifdef CSR_MCYCLE_EN
    logic [2*XLEN-1:0] r_mcycle;
`endif

    logic            w_csr_op, w_use_imm, w_csr_write, w_rd_nz;
    logic            w_trap, w_illegal, w_mret;
    csr_op_e         w_kind;
    logic [3:0]      w_cause;
    logic [11:0]     w_addr;
    logic            w_active, w_do_write, w_do_trap, w_do_mret;
    logic [XLEN-1:0] w_operand, w_old, w_new, w_mstatus;

    csr_decode u_decode (
        .i_inst      (csrunitin_inst),
        .o_csr_op    (w_csr_op),
        .o_csr_kind  (w_kind),
        .o_use_imm   (w_use_imm),
        .o_csr_write (w_csr_write),
        .o_rd_nz     (w_rd_nz),
        .o_trap      (w_trap),
        .o_illegal   (w_illegal),
        .o_mret      (w_mret),
        .o_cause     (w_cause)
    );

    // The slot right after a redirect is squashed: valid is ignored there.
    assign w_active   = csrunitin_valid && (r_state == ST_RUN);
    assign w_addr     = csrunitin_inst[31:20];
    assign w_do_write = w_active && w_csr_op && w_csr_write;
    assign w_do_trap  = w_active && w_trap;
    assign w_do_mret  = w_active && w_mret;
    assign w_operand  = w_use_imm ? {{(XLEN-5){1'b0}}, csrunitin_inst[19:15]} : csrunitin_rs1;

    always_comb begin
        w_mstatus = '0;
        w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        w_mstatus[MSTATUS_MIE]  = r_mie;
        w_mstatus[MSTATUS_MPIE] = r_mpie;
    end

    always_comb begin
        w_old = '0;
        case (w_addr)
            CSR_MSTATUS: w_old = w_mstatus;
            CSR_MTVEC:   w_old = r_mtvec;
            CSR_MEPC:    w_old = r_mepc;
            CSR_MCAUSE:  w_old = r_mcause;
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE,  CSR_CYCLE:  w_old = r_mcycle[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: w_old = r_mcycle[2*XLEN-1:XLEN];
`endif
            default: w_old = '0;
        endcase
    end

    always_comb begin
        case (w_kind)
            CSR_OP_RW: w_new = w_operand;
            CSR_OP_RS: w_new = w_old | w_operand;
            CSR_OP_RC: w_new = w_old & ~w_operand;
            default:   w_new = w_old;
        endcase
    end

    assign csrunitout_rdata       = w_old;
    assign csrunitout_rd_write    = w_active && w_csr_op && w_rd_nz;
    assign csrunitout_illegal     = w_active && w_illegal;
    assign csrunitout_mstatus     = w_mstatus;
    assign csrunitout_redirect    = (r_state == ST_REDIRECT);
    assign csrunitout_redirect_pc = r_redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (w_do_trap || w_do_mret) w_state_next = ST_REDIRECT;
            ST_REDIRECT: w_state_next = ST_RUN;
            default:     w_state_next = ST_RUN;
        endcase
    end

    // Neither trap nor mret modifies its own target, so the pre-edge
    // mtvec/mepc equals the value "as updated at that edge".
    always_ff @(posedge clk) begin
        if (rst)            r_redirect_pc <= '0;
        else if (w_do_trap) r_redirect_pc <= r_mtvec;
        else if (w_do_mret) r_redirect_pc <= r_mepc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtvec  <= MTVEC_RESET;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else if (w_do_trap) begin
            r_mepc   <= {csrunitin_pc[XLEN-1:2], 2'b00} | {{(XLEN-2){1'b0}}, 2'b00 & csrunitin_pc[1:0]};
            r_mcause <= {{(XLEN-4){1'b0}}, w_cause};
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_do_mret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
        end else if (w_do_write) begin
            case (w_addr)
                CSR_MSTATUS: begin
                    r_mie  <= w_new[MSTATUS_MIE];
                    r_mpie <= w_new[MSTATUS_MPIE];
                end
                CSR_MTVEC:  r_mtvec  <= {w_new[XLEN-1:2], 2'b00};
                CSR_MEPC:   r_mepc   <= {w_new[XLEN-1:2], 2'b00};
                CSR_MCAUSE: r_mcause <= w_new;
                default: ;
            endcase
        end
    end

`ifdef CSR_MCYCLE_EN
    // A CSR write to either half replaces that half and skips the increment.
    always_ff @(posedge clk) begin
        if (rst)
            r_mcycle <= '0;
        else if (w_do_write && (w_addr == CSR_MCYCLE))
            r_mcycle[XLEN-1:0] <= w_new;
        else if (w_do_write && (w_addr == CSR_MCYCLEH))
            r_mcycle[2*XLEN-1:XLEN] <= w_new;
        else
            r_mcycle <= r_mcycle + 1'b1;
    end
`endif

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

    localparam logic [31:0] MR = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0, in_rs1 = '0, in_pc = '0;
    logic [31:0] out_rdata, out_rpc, out_mstatus;
    logic        out_rdw, out_red, out_ill;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_unit #(.XLEN(32), .MTVEC_RESET(MR)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .csrunitin_valid        (in_valid),
        .csrunitin_inst         (in_inst),
        .csrunitin_rs1          (in_rs1),
        .csrunitin_pc           (in_pc),
        .csrunitout_rdata       (out_rdata),
        .csrunitout_rd_write    (out_rdw),
        .csrunitout_redirect    (out_red),
        .csrunitout_redirect_pc (out_rpc),
        .csrunitout_illegal     (out_ill),
        .csrunitout_mstatus     (out_mstatus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] inst, rs1, pc;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        rdw, ill, red;
        logic [31:0] rpc, ms;
    } vec_t;

    function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {a, r1, f3, rd, 7'h73};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] inst, rs1, pc,
                                 input logic cr, input logic [31:0] rdata,
                                 input logic rdw, ill, red, input logic [31:0] rpc, ms);
        vec_t t;
        t.valid = v; t.inst = inst; t.rs1 = rs1; t.pc = pc; t.chk_rdata = cr;
        t.rdata = rdata; t.rdw = rdw; t.ill = ill; t.red = red; t.rpc = rpc; t.ms = ms;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, rs1, pc);
        in_valid = v; in_inst = inst; in_rs1 = rs1; in_pc = pc;
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_pend_pc;
    logic [63:0] m_mcycle;
    logic        m_pend, m_cnt_written;

    task automatic m_reset();
        m_mstatus = 32'h1800; m_mtvec = MR; m_mepc = 0; m_mcause = 0;
        m_mcycle = 0; m_pend = 0; m_pend_pc = 0;
    endtask

    task automatic m_read(input logic [11:0] a, output logic ex, output logic ro, output logic [31:0] v);
        ex = 1; ro = 0; v = 0;
        if (a == 12'h300)      v = m_mstatus;
        else if (a == 12'h305) v = m_mtvec;
        else if (a == 12'h341) v = m_mepc;
        else if (a == 12'h342) v = m_mcause;
`ifdef CSR_MCYCLE_EN
        else if (a == 12'hB00) v = m_mcycle[31:0];
        else if (a == 12'hB80) v = m_mcycle[63:32];
        else if (a == 12'hC00) begin v = m_mcycle[31:0];  ro = 1; end
        else if (a == 12'hC80) begin v = m_mcycle[63:32]; ro = 1; end
`endif
        else ex = 0;
    endtask

    task automatic m_write(input logic [11:0] a, input logic [31:0] v);
        if (a == 12'h300)      m_mstatus = (v & 32'h88) | 32'h1800;
        else if (a == 12'h305) m_mtvec = v & ~32'd3;
        else if (a == 12'h341) m_mepc = v & ~32'd3;
        else if (a == 12'h342) m_mcause = v;
        else if (a == 12'hB00) begin m_mcycle[31:0]  = v; m_cnt_written = 1; end
        else if (a == 12'hB80) begin m_mcycle[63:32] = v; m_cnt_written = 1; end
    endtask

    task automatic m_trap(input logic [31:0] pc, input logic [31:0] cause);
        m_mepc = pc & ~32'd3;
        m_mcause = cause;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        m_pend_pc = m_mtvec;
    endtask

    // One cycle: compare DUT against the model's pre-edge view, then advance model.
    task automatic m_cycle(input int n);
        logic [2:0] f3; logic [11:0] a; logic [4:0] z;
        logic ex, ro, wr, e_rdw, e_ill, e_chk, nxt;
        logic [31:0] old, op, nv, e_ms;
        e_ms = m_mstatus; e_rdw = 0; e_ill = 0; e_chk = 0; old = 0; nxt = 0;
        m_cnt_written = 0;
        f3 = in_inst[14:12]; a = in_inst[31:20]; z = in_inst[19:15];
        if (!m_pend && in_valid && in_inst[6:0] == 7'h73) begin
            if (f3 == 3'd0) begin
                nxt = 1;
                if (a == 12'h000)      m_trap(in_pc, 11);
                else if (a == 12'h001) m_trap(in_pc, 3);
                else if (a == 12'h302) begin
                    m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
                    m_pend_pc = m_mepc;
                end else begin e_ill = 1; m_trap(in_pc, 2); end
            end else if (f3 == 3'd4) begin
                e_ill = 1; nxt = 1; m_trap(in_pc, 2);
            end else begin
                m_read(a, ex, ro, old);
                op = f3[2] ? {27'd0, z} : in_rs1;
                wr = (f3[1:0] == 2'd1) || (z != 0);
                if (!ex || (ro && wr)) begin
                    e_ill = 1; nxt = 1; m_trap(in_pc, 2);
                end else begin
                    e_chk = 1;
                    e_rdw = (in_inst[11:7] != 0);
                    if (wr) begin
                        nv = (f3[1:0] == 2'd1) ? op : (f3[1:0] == 2'd2) ? (old | op) : (old & ~op);
                        m_write(a, nv);
                    end
                end
            end
        end
        chk($sformatf("rnd%0d.redirect", n), {31'd0, out_red}, {31'd0, m_pend});
        if (m_pend) chk($sformatf("rnd%0d.redirect_pc", n), out_rpc, m_pend_pc);
        chk($sformatf("rnd%0d.rd_write", n), {31'd0, out_rdw}, {31'd0, e_rdw});
        chk($sformatf("rnd%0d.illegal", n), {31'd0, out_ill}, {31'd0, e_ill});
        if (e_chk) chk($sformatf("rnd%0d.rdata", n), out_rdata, old);
        chk($sformatf("rnd%0d.mstatus", n), out_mstatus, e_ms);
        $display("rnd %0d v=%0b inst=%08h rs1=%08h rdata=%08h rdw=%0b ill=%0b red=%0b",
                 n, in_valid, in_inst, in_rs1, out_rdata, out_rdw, out_ill, out_red);
        if (!m_cnt_written) m_mcycle = m_mcycle + 1;
        m_pend = nxt;
    endtask

    // one hand-written step: drive, then check rdata/illegal/rd_write
    task automatic hand(input string nm, input logic [31:0] inst, rs1,
                        input logic cr, input logic [31:0] rdata, input logic rdw, ill);
        drive(1'b1, inst, rs1, 32'h100);
        if (cr) chk({nm, ".rdata"}, out_rdata, rdata);
        chk({nm, ".rd_write"}, {31'd0, out_rdw}, {31'd0, rdw});
        chk({nm, ".illegal"}, {31'd0, out_ill}, {31'd0, ill});
        $display("hand %s inst=%08h rdata=%08h rdw=%0b ill=%0b", nm, inst, out_rdata, out_rdw, out_ill);
        next_cycle();
    endtask

    vec_t tbl [0:30];
    logic [31:0] ECALL, EBREAK, MRET;

    initial begin
        ECALL  = enc(12'h000, 0, 0, 0);
        EBREAK = enc(12'h001, 0, 0, 0);
        MRET   = enc(12'h302, 0, 0, 0);
        //            v  inst                          rs1           pc      cr rdata         rdw ill red rpc           mstatus
        tbl[0]  = mkv(1, enc(12'h305, 1, 3'b001, 5),  32'h8000_0103, 0,     1, MR,            1, 0, 0, 0,            32'h1800);
        tbl[1]  = mkv(1, enc(12'h305, 0, 3'b010, 6),  0,             0,     1, 32'h8000_0100, 1, 0, 0, 0,            32'h1800);
        tbl[2]  = mkv(1, enc(12'h300, 0, 3'b010, 0),  32'hFFFF_FFFF, 0,     1, 32'h1800,      0, 0, 0, 0,            32'h1800);
        tbl[3]  = mkv(1, enc(12'h300, 8, 3'b110, 7),  0,             0,     1, 32'h1800,      1, 0, 0, 0,            32'h1800);
        tbl[4]  = mkv(1, enc(12'h300, 0, 3'b010, 8),  0,             0,     1, 32'h1808,      1, 0, 0, 0,            32'h1808);
        tbl[5]  = mkv(1, ECALL,                       0,             32'h40, 0, 0,            0, 0, 0, 0,            32'h1808);
        tbl[6]  = mkv(1, enc(12'h305, 1, 3'b001, 9),  32'h1234,      0,     0, 0,             0, 0, 1, 32'h8000_0100, 32'h1880);
        tbl[7]  = mkv(1, enc(12'h341, 0, 3'b010, 10), 0,             0,     1, 32'h40,        1, 0, 0, 0,            32'h1880);
        tbl[8]  = mkv(1, enc(12'h342, 0, 3'b010, 11), 0,             0,     1, 11,            1, 0, 0, 0,            32'h1880);
        tbl[9]  = mkv(1, enc(12'h305, 0, 3'b010, 12), 0,             0,     1, 32'h8000_0100, 1, 0, 0, 0,            32'h1880);
        tbl[10] = mkv(1, MRET,                        0,             32'h50, 0, 0,            0, 0, 0, 0,            32'h1880);
        tbl[11] = mkv(0, 0,                           0,             0,     0, 0,             0, 0, 1, 32'h40,       32'h1888);
        tbl[12] = mkv(1, enc(12'h7C0, 2, 3'b001, 1),  32'h5,         32'h60, 0, 0,            0, 1, 0, 0,            32'h1888);
        tbl[13] = mkv(0, 0,                           0,             0,     0, 0,             0, 0, 1, 32'h8000_0100, 32'h1880);
        tbl[14] = mkv(1, enc(12'h342, 0, 3'b010, 2),  0,             0,     1, 2,             1, 0, 0, 0,            32'h1880);
        tbl[15] = mkv(1, enc(12'h341, 0, 3'b010, 3),  0,             0,     1, 32'h60,        1, 0, 0, 0,            32'h1880);
        tbl[16] = mkv(1, enc(12'h300, 1, 3'b001, 5),  32'hFFFF_FFFF, 0,     1, 32'h1880,      1, 0, 0, 0,            32'h1880);
        tbl[17] = mkv(1, enc(12'h300, 1, 3'b011, 5),  32'h8,         0,     1, 32'h1888,      1, 0, 0, 0,            32'h1888);
        tbl[18] = mkv(1, enc(12'h300, 0, 3'b010, 6),  0,             0,     1, 32'h1880,      1, 0, 0, 0,            32'h1880);
        tbl[19] = mkv(1, EBREAK,                      0,             32'h64, 0, 0,            0, 0, 0, 0,            32'h1880);
        tbl[20] = mkv(0, 0,                           0,             0,     0, 0,             0, 0, 1, 32'h8000_0100, 32'h1800);
        tbl[21] = mkv(1, enc(12'h342, 0, 3'b010, 2),  0,             0,     1, 3,             1, 0, 0, 0,            32'h1800);
        tbl[22] = mkv(1, enc(12'h300, 1, 3'b100, 1),  0,             32'h70, 0, 0,            0, 1, 0, 0,            32'h1800);
        tbl[23] = mkv(0, 0,                           0,             0,     0, 0,             0, 0, 1, 32'h8000_0100, 32'h1800);
        tbl[24] = mkv(1, enc(12'h341, 1, 3'b001, 4),  32'h103,       0,     1, 32'h70,        1, 0, 0, 0,            32'h1800);
        tbl[25] = mkv(1, enc(12'h341, 0, 3'b010, 4),  0,             0,     1, 32'h100,       1, 0, 0, 0,            32'h1800);
        tbl[26] = mkv(1, 32'h0000_0013,               0,             0,     0, 0,             0, 0, 0, 0,            32'h1800);
        tbl[27] = mkv(1, enc(12'h342, 1, 3'b001, 0),  32'hDEAD_BEEF, 0,     0, 0,             0, 0, 0, 0,            32'h1800);
        tbl[28] = mkv(1, enc(12'h342, 0, 3'b010, 1),  0,             0,     1, 32'hDEAD_BEEF, 1, 0, 0, 0,            32'h1800);
        tbl[29] = mkv(0, enc(12'h305, 1, 3'b001, 1),  32'h4444,      0,     0, 0,             0, 0, 0, 0,            32'h1800);
        tbl[30] = mkv(1, enc(12'h305, 0, 3'b010, 1),  0,             0,     1, 32'h8000_0100, 1, 0, 0, 0,            32'h1800);

        // reset state
        do_reset();
        drive(0, 0, 0, 0);
        chk("reset.redirect", {31'd0, out_red}, 0);
        chk("reset.redirect_pc", out_rpc, 0);
        chk("reset.mstatus", out_mstatus, 32'h1800);
        chk("reset.illegal", {31'd0, out_ill}, 0);
        next_cycle();

        // directed table
        for (int i = 0; i <= 30; i++) begin
            drive(tbl[i].valid, tbl[i].inst, tbl[i].rs1, tbl[i].pc);
            chk($sformatf("vec%0d.redirect", i), {31'd0, out_red}, {31'd0, tbl[i].red});
            if (tbl[i].red) chk($sformatf("vec%0d.redirect_pc", i), out_rpc, tbl[i].rpc);
            chk($sformatf("vec%0d.rd_write", i), {31'd0, out_rdw}, {31'd0, tbl[i].rdw});
            chk($sformatf("vec%0d.illegal", i), {31'd0, out_ill}, {31'd0, tbl[i].ill});
            if (tbl[i].chk_rdata) chk($sformatf("vec%0d.rdata", i), out_rdata, tbl[i].rdata);
            chk($sformatf("vec%0d.mstatus", i), out_mstatus, tbl[i].ms);
            $display("vec %0d inst=%08h rdata=%08h rdw=%0b ill=%0b red=%0b rpc=%08h ms=%08h",
                     i, tbl[i].inst, out_rdata, out_rdw, out_ill, out_red, out_rpc, out_mstatus);
            next_cycle();
        end

        // reset asserted during the redirect cycle
        do_reset();
        hand("rst_redir.ill", enc(12'h7C0, 1, 3'b001, 1), 32'h1, 0, 0, 0, 1);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        chk("rst_redir.pulse", {31'd0, out_red}, 1);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("rst_redir.redirect", {31'd0, out_red}, 0);
        chk("rst_redir.redirect_pc", out_rpc, 0);
        chk("rst_redir.mstatus", out_mstatus, 32'h1800);
        next_cycle();
        hand("rst_redir.mepc", enc(12'h341, 0, 3'b010, 1), 0, 1, 0, 1, 0);
        hand("rst_redir.mcause", enc(12'h342, 0, 3'b010, 1), 0, 1, 0, 1, 0);
        hand("rst_redir.mtvec", enc(12'h305, 0, 3'b010, 1), 0, 1, MR, 1, 0);

        // counter corner cases
`ifdef CSR_MCYCLE_EN
        do_reset();
        hand("mcyc.wr_lo_a", enc(12'hB00, 1, 3'b001, 1), 32'hFFFF_FFFF, 1, 0, 1, 0);
        drive(0, 0, 0, 0); next_cycle();
        hand("mcyc.hi", enc(12'hB80, 0, 3'b010, 1), 0, 1, 1, 1, 0);
        do_reset();
        hand("mcyc.wr_lo_b", enc(12'hB00, 1, 3'b001, 1), 32'hFFFF_FFFF, 1, 0, 1, 0);
        drive(0, 0, 0, 0); next_cycle();
        hand("mcyc.lo", enc(12'hB00, 0, 3'b010, 1), 0, 1, 0, 1, 0);
        hand("mcyc.ro_write", enc(12'hC00, 1, 3'b001, 1), 32'h5, 0, 0, 0, 1);
        drive(0, 0, 0, 0); next_cycle();
        hand("mcyc.ro_read", enc(12'hC80, 0, 3'b010, 1), 0, 1, 1, 1, 0);
`else
        do_reset();
        hand("nocnt.b00", enc(12'hB00, 0, 3'b010, 1), 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0); next_cycle();
        hand("nocnt.c80", enc(12'hC80, 0, 3'b010, 1), 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0); next_cycle();
`endif

        // randomized run against the reference model
        do_reset();
        m_reset();
        for (int n = 0; n < 500; n++) begin
            int r;
            logic [11:0] addrs [0:9];
            logic [2:0]  f3s   [0:5];
            logic [31:0] inst;
            addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                      12'hC00, 12'hC80, 12'h7C0, 12'h301};
            f3s = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
            r = $urandom_range(0, 99);
            if (r < 5)       inst = ECALL;
            else if (r < 8)  inst = EBREAK;
            else if (r < 13) inst = MRET;
            else if (r < 16) inst = $urandom;
            else if (r < 18) inst = enc(12'h300, 5'($urandom), 3'b100, 5'($urandom));
            else inst = enc(addrs[$urandom_range(0, 9)],
                            ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom),
                            f3s[$urandom_range(0, 5)],
                            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
            drive($urandom_range(0, 9) != 0, inst, $urandom, $urandom & ~32'd3);
            m_cycle(n);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
